// File: rtl/sample_packer.sv
// sample_packer: samples probe inputs at a programmable rate and packs 16/8/4/2-channel samples into OUT_W-bit FIFO words.
// Latency: a probe value before edge n appears with sample_data_avail at edge n+2 (16ch, divider=0); +1 edge with TRIGGER_EN.
// Backpressure: fifo_full when a word completes drops that word, sets sticky overflow and parks in OVF until enable is cycled.
// Optional: define TRIGGER_EN to add an ARMED state that waits for a masked probe match (trig_mask, trig_value, armed).
module sample_packer #(
  parameter int PROBE_W = 16,
  parameter int OUT_W   = 16,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         chan_mode,
  input  logic [DIV_W-1:0]   divider,
  input  logic [PROBE_W-1:0] probe,
  input  logic               fifo_full,
`ifdef TRIGGER_EN
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  output logic               armed,
`endif
  output logic [OUT_W-1:0]   sample_data,
  output logic               sample_data_avail,
  output logic               overflow,
  output logic               running,
  output logic [CNT_W-1:0]   word_count
);

  // Lane index must reach OUT_W/2-1 (2-channel mode).
  localparam int LANE_W = $clog2(OUT_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_OVF   = 2'd2;
`ifdef TRIGGER_EN
  localparam logic [1:0] S_ARMED = 2'd3;
`endif

  logic [1:0]         state_q, state_d;
  logic [PROBE_W-1:0] probe_q;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [OUT_W-1:0]   pack_q, pack_d;
  logic               complete_q, complete_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               avail_q, avail_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        src;
  logic [3:0]         chmask;
  logic [2:0]         shift;
  logic [LANE_W-1:0]  last_lane;
  logic               sample_now;
  logic               push;
  logic               push_ok;
  logic               push_drop;

`ifdef TRIGGER_EN
  // One extra probe delay so the sample that matched the trigger in ARMED
  // is the first sample packed in RUN.
  logic [15:0]        samp_q;
  logic               trig_hit;
  assign trig_hit = ((probe_q & trig_mask) == (trig_value & trig_mask));
  assign src      = samp_q;
  assign armed    = (state_q == S_ARMED);
`else
  assign src      = probe_q[15:0];
`endif

  // Channel count C = 16>>mode: mask selects probe bit, shift maps word bit to lane.
  assign chmask     = 4'hF >> mode_q;
  assign shift      = 3'd4 - {1'b0, mode_q};
  assign last_lane  = LANE_W'((OUT_W >> shift) - 1);
  assign sample_now = (state_q == S_RUN) && (div_cnt_q == '0);

  // A completed word is pushed one clock after its last sample, even if the
  // FSM has just left RUN for IDLE; OVF suppresses any further push.
  assign push      = complete_q && (state_q != S_OVF);
  assign push_ok   = push && !fifo_full;
  assign push_drop = push && fifo_full;

  // Next-state logic: sampling/packing, push and overflow, FSM transitions.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    complete_d = 1'b0;
    data_d     = data_q;
    avail_d    = 1'b0;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    if (sample_now) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (LANE_W'(i >> shift) == lane_q) pack_d[i] = src[4'(i) & chmask];
      end
      complete_d = (lane_q == last_lane);
      lane_d     = (lane_q == last_lane) ? '0 : lane_q + 1'b1;
    end

    if (state_q == S_RUN) div_cnt_d = (div_cnt_q == div_q) ? '0 : div_cnt_q + 1'b1;

    if (push_ok) begin
      data_d  = pack_q;
      avail_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end
    if (push_drop) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          mode_d    = chan_mode;
          div_d     = divider;
          div_cnt_d = '0;
          lane_d    = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
`ifdef TRIGGER_EN
          state_d   = S_ARMED;
`else
          state_d   = S_RUN;
`endif
        end
      end
`ifdef TRIGGER_EN
      S_ARMED: begin
        if (!enable)       state_d = S_IDLE;
        else if (trig_hit) state_d = S_RUN;
      end
`endif
      S_RUN: begin
        if (!enable)        state_d = S_IDLE;
        else if (push_drop) state_d = S_OVF;
      end
      S_OVF: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; everything clears asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      probe_q    <= '0;
      mode_q     <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      complete_q <= 1'b0;
      data_q     <= '0;
      avail_q    <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef TRIGGER_EN
      samp_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      probe_q    <= probe;
      mode_q     <= mode_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      complete_q <= complete_d;
      data_q     <= data_d;
      avail_q    <= avail_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
`ifdef TRIGGER_EN
      samp_q     <= probe_q[15:0];
`endif
    end
  end

  assign sample_data       = data_q;
  assign sample_data_avail = avail_q;
  assign overflow          = ovf_q;
  assign running           = (state_q == S_RUN);
  assign word_count        = cnt_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: drives sample_packer through channel modes, dividers, overflow, stop and reset cases.
// Latency: expected words carry the edge on which their push must appear.
// Backpressure: fifo_full is raised exactly on the completion edge of a chosen word.
module tb_sample_packer;
  localparam int PROBE_W = 16;
  localparam int OUT_W   = 16;
  localparam int DIV_W   = 16;
  localparam int CNT_W   = 32;
`ifdef TRIGGER_EN
  localparam int TL = 1;
`else
  localparam int TL = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         chan_mode = 2'd0;
  logic [DIV_W-1:0]   divider = '0;
  logic [PROBE_W-1:0] probe = '0;
  logic               fifo_full = 1'b0;
  logic [OUT_W-1:0]   sample_data;
  logic               sample_data_avail;
  logic               overflow;
  logic               running;
  logic [CNT_W-1:0]   word_count;
`ifdef TRIGGER_EN
  logic [PROBE_W-1:0] trig_mask = '0;
  logic [PROBE_W-1:0] trig_value = '0;
  logic               armed;
`endif

  typedef struct {
    logic [OUT_W-1:0] d;
    int               e;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         full_edge = -1;
  int         n_chk = 0;
  int         n_err = 0;
  int         seen = 0;
  int         e0;
  logic [7:0] tab8 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  sample_packer #(
    .PROBE_W(PROBE_W), .OUT_W(OUT_W), .DIV_W(DIV_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .chan_mode(chan_mode),
    .divider(divider),
    .probe(probe),
    .fifo_full(fifo_full),
`ifdef TRIGGER_EN
    .trig_mask(trig_mask),
    .trig_value(trig_value),
    .armed(armed),
`endif
    .sample_data(sample_data),
    .sample_data_avail(sample_data_avail),
    .overflow(overflow),
    .running(running),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: apply fifo_full for the coming edge, then score any push.
  task automatic step();
    exp_t e;
    fifo_full = (cyc + 1 == full_edge);
    @(posedge clk);
    cyc++;
    #1;
    if (sample_data_avail) begin
      check("push_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        seen++;
        check("data", sample_data, e.d);
        check("push_edge", cyc, e.e);
        check("word_count", word_count, seen);
      end
    end
  endtask

  // Run nsamp samples in one capture; word full_at (if >=0) meets fifo_full.
  task automatic run_case(input logic [1:0] mode, input int div, input int nsamp,
                          input int pat, input int full_at);
    int c, l, per, t, nexp, m, k, w;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   last_exp;
    logic [PROBE_W-1:0] p;
    c = 16 >> mode;
    l = OUT_W / c;
    per = div + 1;
    t = nsamp * per + TL;
    e0 = cyc + 1;
    nexp = 0;
    seen = 0;
    acc = '0;
    last_exp = '0;
    chan_mode = mode;
    divider = DIV_W'(div);
    for (int j = 0; j < t; j++) begin
      case (pat)
        0:       p = PROBE_W'(j + 1);
        1:       p = {8'(j) ^ 8'hFF, tab8[(j / per) % 4]};
        2:       p = 16'hFFFE;
        default: p = PROBE_W'($urandom);
      endcase
      enable = 1'b1;
      probe = p;
      if ((j % per == 0) && (j / per < nsamp)) begin
        m = j / per;
        k = m % l;
        for (int b = 0; b < c; b++) acc[k * c + b] = p[b];
        if (k == l - 1) begin
          w = m / l;
          if (full_at < 0 || w < full_at) begin
            sb.push_back('{acc, e0 + j + 2 + TL});
            last_exp = acc;
            nexp++;
          end else if (w == full_at) begin
            full_edge = e0 + j + 2 + TL;
          end
        end
      end
      step();
      if (j == 0) begin
        check("wc_clear_on_start", word_count, 0);
        check("ovf_clear_on_start", overflow, 0);
      end
      if (j == TL) check("running_on", running, 1);
    end
    enable = 1'b0;
    step();
    check("running_off", running, 0);
    repeat (l * per + 3) step();
    full_edge = -1;
    check("sb_left", sb.size(), 0);
    check("wc_final", word_count, nexp);
    check("ovf_final", overflow, (full_at >= 0 && full_at < nsamp / l));
    if (nexp > 0) check("data_hold", sample_data, last_exp);
    sb.delete();
  endtask

  initial begin
    repeat (2) step();
    check("rst_data", sample_data, 0);
    check("rst_avail", sample_data_avail, 0);
    check("rst_ovf", overflow, 0);
    check("rst_running", running, 0);
    check("rst_wc", word_count, 0);
    rst = 1'b1;
    step();

    run_case(2'd0, 0, 8, 0, -1);   // 16ch ramp, one word per cycle
    run_case(2'd1, 0, 4, 1, -1);   // 8ch: 0xB2A1, 0xD4C3
    run_case(2'd3, 3, 16, 2, -1);  // 2ch div3: 0xAAAA every 32 cycles
    run_case(2'd0, 0, 6, 0, 2);    // full on third word: 2 pushes, overflow
    run_case(2'd2, 0, 3, 3, -1);   // 4ch partial word discarded
    run_case(2'd2, 0, 8, 3, -1);   // restart at lane 0
    run_case(2'd1, 2, 6, 3, -1);   // 8ch with divider 2

`ifdef TRIGGER_EN
    trig_mask = 16'h0003;
    trig_value = 16'h0002;
    chan_mode = 2'd0;
    divider = '0;
    seen = 0;
    e0 = cyc + 1;
    sb.push_back('{16'h0002, e0 + 5});
    sb.push_back('{16'h0003, e0 + 6});
    for (int j = 0; j < 5; j++) begin
      enable = 1'b1;
      probe = PROBE_W'(j);
      step();
      if (j < 3) check("armed", armed, 1);
      if (j == 3) check("trig_running", running, 1);
    end
    enable = 1'b0;
    repeat (4) step();
    check("trig_sb_left", sb.size(), 0);
    sb.delete();
    trig_mask = '0;
    trig_value = '0;
`endif

    // Asynchronous reset in the middle of a run.
    chan_mode = 2'd0;
    divider = '0;
    seen = 0;
    e0 = cyc + 1;
    sb.push_back('{16'h55AA, e0 + 2 + TL});
    sb.push_back('{16'h55AA, e0 + 3 + TL});
    enable = 1'b1;
    probe = 16'h55AA;
    repeat (4 + TL) step();
    rst = 1'b0;
    #2;
    check("arst_data", sample_data, 0);
    check("arst_avail", sample_data_avail, 0);
    check("arst_ovf", overflow, 0);
    check("arst_running", running, 0);
    check("arst_wc", word_count, 0);
    sb.delete();
    enable = 1'b0;
    rst = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

endmodule
